// File: rtl/weighted_mean_seq.sv
// Weighted mean of N_INPUT unsigned channels: sum(in*weight)/sum(weight), floor or round-half-up.
// Latency: out_valid N_INPUT+SIZE edges after accept (N_INPUT+1 when all weights are zero).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, new inputs ignored meanwhile.
module weighted_mean_seq #(
  parameter int N_INPUT = 4,
  parameter int SIZE    = 32,
  parameter int ROUND   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_INPUT*SIZE-1:0]   in,
  input  logic [N_INPUT*SIZE-1:0]   weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZE-1:0]           mean,
  output logic                      div_zero,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_INPUT);
  localparam int BC_W  = $clog2(SIZE);
  localparam int WS_W  = SIZE + IDX_W;
  localparam int ACC_W = 2 * SIZE + IDX_W + 1;
  // Partial remainder width: the dividend bits above the quotient field.
  localparam int REM_W = ACC_W - SIZE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUT - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state;
  logic [SIZE-1:0]    in_r     [N_INPUT];
  logic [SIZE-1:0]    weight_r [N_INPUT];
  logic [ACC_W-1:0]   acc;
  logic [WS_W-1:0]    wsum;
  logic [IDX_W-1:0]   idx;
  logic [BC_W-1:0]    bit_cnt;
  logic [REM_W-1:0]   rem;
  logic [SIZE-1:0]    quo;

  logic [2*SIZE-1:0]  prod;
  logic [ACC_W-1:0]   dividend;
  logic               div_first;
  logic [REM_W-1:0]   rem_src;
  logic [SIZE-1:0]    quo_src;
  logic [REM_W-1:0]   rem_shift;
  logic               q_bit;
  logic [REM_W-1:0]   rem_next;
  logic [SIZE-1:0]    quo_next;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Shared multiplier on the current channel.
  assign prod = (2*SIZE)'(in_r[idx]) * (2*SIZE)'(weight_r[idx]);

  // Rounding adds half the divisor before the floor division.
  assign dividend = (ROUND != 0) ? (acc + ACC_W'(wsum >> 1)) : acc;

  // First DIV cycle seeds the divider from the dividend and also produces the first quotient bit,
  // so that exactly SIZE edges are spent in DIV. The quotient shares the low-bit shift register
  // with the not-yet-consumed dividend bits.
  always_comb begin
    div_first = (bit_cnt == '0);
    rem_src   = div_first ? dividend[ACC_W-1:SIZE] : rem;
    quo_src   = div_first ? dividend[SIZE-1:0]     : quo;
    rem_shift = (rem_src << 1) | REM_W'(quo_src[SIZE-1]);
    q_bit     = (rem_shift >= REM_W'(wsum));
    rem_next  = q_bit ? (rem_shift - REM_W'(wsum)) : rem_shift;
    quo_next  = (quo_src << 1) | SIZE'(q_bit);
  end

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mean      <= '0;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      acc       <= '0;
      wsum      <= '0;
      idx       <= '0;
      bit_cnt   <= '0;
      rem       <= '0;
      quo       <= '0;
      for (int i = 0; i < N_INPUT; i++) begin
        in_r[i]     <= '0;
        weight_r[i] <= '0;
      end
    end else if (clear) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_INPUT; i++) begin
              in_r[i]     <= in[i*SIZE +: SIZE];
              weight_r[i] <= weight[i*SIZE +: SIZE];
            end
            acc   <= '0;
            wsum  <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc  <= acc + ACC_W'(prod);
          wsum <= wsum + WS_W'(weight_r[idx]);
          if (idx == LAST_IDX) begin
            bit_cnt <= '0;
            state   <= S_DIV;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DIV: begin
          if (div_first && (wsum == '0)) begin
            mean      <= '0;
            div_zero  <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            if (div_first) begin
              div_zero <= 1'b0;
            end
            rem     <= rem_next;
            quo     <= quo_next;
            bit_cnt <= bit_cnt + BC_W'(1);
            if (bit_cnt == LAST_BIT) begin
              mean      <= quo_next;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_mean_seq.sv
// Bench for weighted_mean_seq: truncating and rounding instances share stimulus.
// Latency: each result checked against an arbitrary-precision arithmetic model.
// Backpressure: random out_ready hold-off with ignored in_valid pulses while results wait.
module tb_weighted_mean_seq;

  localparam int N    = 4;
  localparam int SIZE = 32;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic              out_ready;
  logic [N*SIZE-1:0] in_bus;
  logic [N*SIZE-1:0] weight_bus;

  logic              in_ready0, out_valid0, div_zero0, busy0;
  logic              in_ready1, out_valid1, div_zero1, busy1;
  logic [SIZE-1:0]   mean0, mean1;

  int n_checks;
  int n_fail;
  logic [SIZE-1:0] last_mean0, last_mean1;

  weighted_mean_seq #(.N_INPUT(N), .SIZE(SIZE), .ROUND(0)) u_trunc (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in(in_bus), .weight(weight_bus),
    .out_valid(out_valid0), .out_ready(out_ready),
    .mean(mean0), .div_zero(div_zero0), .busy(busy0)
  );

  weighted_mean_seq #(.N_INPUT(N), .SIZE(SIZE), .ROUND(1)) u_round (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in(in_bus), .weight(weight_bus),
    .out_valid(out_valid1), .out_ready(out_ready),
    .mean(mean1), .div_zero(div_zero1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*SIZE-1:0] pack4(input logic [SIZE-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: exact rational arithmetic in 128 bits, floor or round-half-up.
  function automatic logic [SIZE-1:0] ref_mean(input logic [N*SIZE-1:0] iv, input logic [N*SIZE-1:0] wv,
                                               input int rnd);
    logic [127:0] num, den;
    num = '0;
    den = '0;
    for (int i = 0; i < N; i++) begin
      num += 128'(iv[i*SIZE +: SIZE]) * 128'(wv[i*SIZE +: SIZE]);
      den += 128'(wv[i*SIZE +: SIZE]);
    end
    if (den == 0) return '0;
    if (rnd != 0) num += den / 2;
    return SIZE'(num / den);
  endfunction

  function automatic logic [N*SIZE-1:0] rand_bus();
    logic [N*SIZE-1:0] b;
    for (int i = 0; i < N; i++) b[i*SIZE +: SIZE] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!in_ready0 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!in_ready0) check("idle_timeout", 64'(in_ready0), 64'd1);
  endtask

  // Accept one vector, measure latency, check both results, then drain with optional hold-off.
  task automatic run_vec(input string tag, input logic [N*SIZE-1:0] iv, input logic [N*SIZE-1:0] wv,
                         input int hold);
    logic [SIZE-1:0] e0, e1;
    logic            ez;
    int              lat, cyc;
    e0  = ref_mean(iv, wv, 0);
    e1  = ref_mean(iv, wv, 1);
    ez  = (wv == '0);
    lat = ez ? N + 1 : N + SIZE;
    wait_idle();
    in_bus     = iv;
    weight_bus = wv;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_bus     = rand_bus();
    weight_bus = rand_bus();
    cyc = 0;
    while (!out_valid0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_ov_round"}, 64'(out_valid1), 64'd1);
    check({tag, "_mean_trunc"}, 64'(mean0), 64'(e0));
    check({tag, "_mean_round"}, 64'(mean1), 64'(e1));
    check({tag, "_dz_trunc"}, 64'(div_zero0), 64'(ez));
    check({tag, "_dz_round"}, 64'(div_zero1), 64'(ez));
    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'($urandom % 2);
      in_bus     = rand_bus();
      weight_bus = rand_bus();
      tick();
      check({tag, "_hold_ov"}, 64'(out_valid0), 64'd1);
      check({tag, "_hold_mean"}, 64'(mean0), 64'(e0));
      check({tag, "_hold_rdy"}, 64'(in_ready0), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_ov"}, 64'(out_valid0), 64'd0);
    check({tag, "_drain_idle"}, 64'(busy0 | busy1), 64'd0);
    check({tag, "_mean_kept"}, 64'(mean1), 64'(e1));
    last_mean0 = e0;
    last_mean1 = e1;
  endtask

  initial begin
    int ov_seen;
    logic [N*SIZE-1:0] iv, wv;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_bus     = '0;
    weight_bus = '0;
    last_mean0 = '0;
    last_mean1 = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_mean", 64'(mean0), 64'd0);
    check("rst_ov", 64'(out_valid0 | out_valid1), 64'd0);
    check("rst_dz", 64'(div_zero0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_in_ready", 64'(in_ready0), 64'd1);

    run_vec("eq_w", pack4(10, 20, 30, 40), pack4(1, 1, 1, 1), 0);
    run_vec("lin_w", pack4(10, 20, 30, 40), pack4(1, 2, 3, 4), 0);
    run_vec("half", pack4(1, 2, 0, 0), pack4(1, 1, 0, 0), 0);
    run_vec("zero_w", pack4(5, 6, 7, 8), pack4(0, 0, 0, 0), 0);
    run_vec("after_zero", pack4(7, 9, 9, 9), pack4(1, 0, 0, 0), 0);
    run_vec("all_ones", {N{32'hFFFF_FFFF}}, {N{32'hFFFF_FFFF}}, 0);
    run_vec("backpress", pack4(3, 100, 1000, 7), pack4(2, 5, 1, 9), 10);
    // Pulses during hold-off must not have been queued.
    repeat (3) tick();
    check("no_queue_busy", 64'(busy0), 64'd0);
    check("no_queue_ov", 64'(out_valid0), 64'd0);

    // Abort mid-MAC: back to IDLE next cycle, nothing emitted, mean untouched.
    wait_idle();
    in_bus     = pack4(11, 22, 33, 44);
    weight_bus = pack4(4, 3, 2, 1);
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 64'(busy0 | busy1), 64'd0);
    check("clr_in_ready", 64'(in_ready0), 64'd1);
    ov_seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (out_valid0 || out_valid1) ov_seen++;
    end
    check("clr_no_ov", 64'(ov_seen), 64'd0);
    check("clr_mean", 64'(mean0), 64'(last_mean0));

    // Reset mid-DIV: outputs go to reset values without waiting for a clock edge.
    wait_idle();
    in_bus     = pack4(50, 60, 70, 80);
    weight_bus = pack4(1, 1, 1, 1);
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (N + 6) tick();
    check("pre_rst_busy", 64'(busy0), 64'd1);
    reset = 1'b0;
    #1;
    check("arst_mean", 64'(mean0 | mean1), 64'd0);
    check("arst_ov", 64'(out_valid0), 64'd0);
    check("arst_dz", 64'(div_zero0), 64'd0);
    check("arst_busy", 64'(busy0), 64'd0);
    tick();
    reset = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (out_valid0) ov_seen++;
    end
    check("arst_no_ov", 64'(ov_seen), 64'd0);

    // Randomized vectors across magnitude classes and hold-off lengths.
    for (int t = 0; t < 30; t++) begin
      iv = rand_bus();
      wv = rand_bus();
      case ($urandom % 4)
        0: ;
        1: for (int i = 0; i < N; i++) begin
             iv[i*SIZE +: SIZE] = $urandom % 256;
             wv[i*SIZE +: SIZE] = $urandom % 16;
           end
        2: for (int i = 0; i < N; i++) if ($urandom % 2) wv[i*SIZE +: SIZE] = '0;
        default: begin
          if ($urandom % 3 == 0) wv = '0;
          else for (int i = 0; i < N; i++) wv[i*SIZE +: SIZE] = $urandom % 3;
        end
      endcase
      run_vec("rand", iv, wv, int'($urandom % 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weighted_mean_seq.md
Name: weighted_mean_seq

Overview:
- Sequential, parametrised weighted-mean engine: mean = floor or round of sum(in[i]*weight[i]) / sum(weight[i]) over N_INPUT channels.
- One shared multiplier and a restoring divider replace the fully combinational multiply and divide.
- valid/ready handshakes on the input and output sides.
- Sits between the per-channel measurement registers and downstream averaging and reporting logic.

Parameters:
- N_INPUT, 4, channel count (>=2).
- SIZE, 32, width of each input sample, each weight, and the result.
- ROUND, 0, 0 = truncate (floor); 1 = round half up.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort, active high; returns FSM to IDLE.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block accepts a vector.
- in  input  N_INPUT*SIZE  samples; channel i = in[i*SIZE +: SIZE], unsigned.
- weight  input  N_INPUT*SIZE  weights; same packing, unsigned.
- out_valid  output  1  mean valid.
- out_ready  input  1  downstream accepts mean.
- mean  output  SIZE  weighted mean, unsigned.
- div_zero  output  1  all weights were zero for the current result.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Widths: product 2*SIZE; wsum width WS_W = SIZE+clog2(N_INPUT); acc width ACC_W = 2*SIZE+clog2(N_INPUT)+1. No overflow is possible.
- Reset (reset=0, async): state=IDLE; mean=0; out_valid=0; div_zero=0; acc=0; wsum=0; channel counter=0; bit counter=0; in_ready=1 once reset is released; busy=0.
- States:
  - IDLE: in_ready=1. When in_valid=1 at a clock edge, capture in and weight into internal registers, clear acc and wsum, set channel idx=0, go to MAC. in and weight may change after the accept edge.
  - MAC: one channel per cycle: acc += in_r[idx]*weight_r[idx], wsum += weight_r[idx]. After N_INPUT cycles go to DIV.
  - DIV entry (first DIV cycle):
    - If wsum==0: mean=0, div_zero=1, out_valid=1, go to DONE with no iteration.
    - Otherwise: if ROUND=1, dividend = acc + (wsum>>1); else dividend = acc. div_zero=0.
  - DIV iteration: restoring division producing exactly SIZE quotient bits, one bit per cycle, MSB first. The partial remainder starts at dividend>>SIZE. This is legal because the quotient is <= max(in) < 2^SIZE, including with rounding.
  - DIV exit: on the edge producing the last quotient bit, mean is loaded and out_valid=1; go to DONE.
  - DONE: mean, div_zero and out_valid are held stable while out_ready=0. When out_valid&&out_ready at an edge: out_valid=0, go to IDLE. mean and div_zero keep their last value until the next result.
- Latency: with accept at edge E0, out_valid rises at edge E0+N_INPUT+SIZE (36 for defaults). For div_zero it rises at edge E0+N_INPUT+1.
- Throughput: one result per N_INPUT+SIZE+2 cycles minimum. in_ready is high only in IDLE, so there is no accept in DONE.
- Priority:
  - reset over clear.
  - clear over all handshakes: from any state go to IDLE and drop out_valid. mean is unchanged.
  - in_valid asserted outside IDLE is ignored and not queued.
- Reset or clear mid-MAC or mid-DIV aborts the computation; no partial result is emitted.
- in_ready, busy and out_valid are registered-state decodes, glitch-free.

Test Plan:
- in={10,20,30,40}, weight={1,1,1,1}, ROUND=0 -> mean=25, div_zero=0, out_valid exactly 36 cycles after accept.
- in={10,20,30,40}, weight={1,2,3,4} -> mean=30 (300/10).
- in={1,2,0,0}, weight={1,1,0,0} -> mean=1 with ROUND=0; mean=2 with ROUND=1.
- All weights 0 -> div_zero=1, mean=0, out_valid 5 cycles after accept; next vector with weight={1,0,0,0}, in={7,..} -> div_zero=0, mean=7.
- All in=0xFFFFFFFF, all weight=0xFFFFFFFF -> mean=0xFFFFFFFF, for both ROUND values.
- Backpressure and abort cases:
  - out_ready held low 10 cycles after out_valid: mean and out_valid stable, in_ready=0, in_valid pulses ignored.
  - clear mid-MAC: IDLE next cycle, no out_valid.
  - reset low mid-DIV: all outputs at reset values immediately.
